// File: rtl/camlink_frame_gate_if.sv
// Camera Link capture bus: deserialised channel ports and timing bits in, packed pixels out.
// Carries no logic of its own; timing is defined by camlink_frame_gate.
// fifo_full travels with the bus so the sink's backpressure stays next to the write strobe.
interface camlink_frame_gate_if #(
  parameter int NCH = 2
) ();
  logic [24*NCH-1:0] port_in;
  logic [NCH-1:0]    lval;
  logic [NCH-1:0]    fval;
  logic [NCH-1:0]    dval;
  logic              fifo_full;
  logic [24*NCH-1:0] pix_o;
  logic              pix_vld;

  // Source / sink side: drives camera signals and backpressure, observes pixels.
  modport master (
    output port_in, lval, fval, dval, fifo_full,
    input  pix_o, pix_vld
  );

  // Capture block side.
  modport slave (
    input  port_in, lval, fval, dval, fifo_full,
    output pix_o, pix_vld
  );
endinterface

// File: rtl/camlink_frame_gate.sv
// Gates exactly one Camera Link frame per arm request and packs beats into pixel words.
// Latency: pix_o/pix_vld appear 2 cycles after the qualifying input beat.
// Backpressure: no stall; a beat arriving while fifo_full=1 is dropped and flagged in err[1].
module camlink_frame_gate #(
  parameter int NCH     = 2,
  parameter int CW      = 16,
  parameter int DVAL_EN = 1
) (
  input  logic          rxclk_div_1,
  input  logic          sys_rst,
  input  logic          locked,
  camlink_frame_gate_if.slave cl,
  input  logic          mode12,
  input  logic          arm,
  input  logic          abort,
  input  logic [CW-1:0] line_width,
  output logic          busy,
  output logic          frame_done,
  output logic [CW-1:0] line_cnt,
  output logic [2:0]    err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    WAIT_SOF = 3'd2,
    ACTIVE   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  // Registered copies of the camera inputs; all decisions use these.
  logic [24*NCH-1:0] port_r;
  logic [NCH-1:0]    lval_r;
  logic [NCH-1:0]    fval_r;
  logic [NCH-1:0]    dval_r;
  // Previous value of channel-0 timing bits, for edge detection.
  logic              fval0_d;
  logic              lval0_d;

  // Packing mode frozen at arm time so a mid-frame change cannot split a frame.
  logic              mode_q;

  logic [CW-1:0]     pix_cnt;
  logic [CW-1:0]     pix_cnt_d;
  logic [CW-1:0]     line_ctr;
  logic [CW-1:0]     line_ctr_d;
  logic [2:0]        err_d;

  logic              beat;
  logic              fval_rise;
  logic              fval_fall;
  logic              lval_rise;
  logic              lval_fall;
  logic              kill;
  logic              in_active;
  logic              cnt_beat;
  logic              arm_take;
  logic              misalign;
  logic [CW-1:0]     step;
  logic [CW:0]       pix_sum;
  logic [CW-1:0]     pix_sat;
  logic [CW:0]       line_sum;
  logic [CW-1:0]     line_sat;
  logic [24*NCH-1:0] packed_pix;

  // Qualification and edge detection on the registered inputs.
  always_comb begin
    beat      = (&lval_r) & (&fval_r) & ((DVAL_EN != 0) ? (&dval_r) : 1'b1);
    fval_rise = fval_r[0] & ~fval0_d;
    fval_fall = ~fval_r[0] & fval0_d;
    lval_rise = lval_r[0] & ~lval0_d;
    lval_fall = ~lval_r[0] & lval0_d;
    // Abort and loss of lock share one path; neither affects IDLE.
    kill      = (state_q != IDLE) & (abort | ~locked);
    in_active = (state_q == ACTIVE);
    cnt_beat  = in_active & beat;
    // Channels disagree when some, but not all, bits of a timing vector are set.
    misalign  = ((|fval_r) & ~(&fval_r)) | ((|lval_r) & ~(&lval_r));
  end

  // Per-channel packing of the registered port bytes {C,B,A}.
  always_comb begin
    packed_pix = '0;
    for (int c = 0; c < NCH; c++) begin
      if (mode_q) begin
        // Two 12-bit pixels: B's high nibble extends C, B's low nibble extends A.
        packed_pix[24*c +: 24] = {port_r[24*c+12 +: 4], port_r[24*c+16 +: 8],
                                  port_r[24*c+8 +: 4],  port_r[24*c +: 8]};
      end else begin
        packed_pix[24*c +: 24] = port_r[24*c +: 24];
      end
    end
  end

  // Pixel and line counter next values with saturation.
  always_comb begin
    step     = mode_q ? CW'(2*NCH) : CW'(3*NCH);
    pix_sum  = {1'b0, pix_cnt} + {1'b0, step};
    pix_sat  = pix_sum[CW] ? {CW{1'b1}} : pix_sum[CW-1:0];
    line_sum = {1'b0, line_ctr} + {{CW{1'b0}}, 1'b1};
    line_sat = line_sum[CW] ? {CW{1'b1}} : line_sum[CW-1:0];

    pix_cnt_d = pix_cnt;
    if (lval_rise) begin
      // A beat on the first cycle of a line is the first pixel group of that line.
      pix_cnt_d = cnt_beat ? step : '0;
    end else if (cnt_beat) begin
      pix_cnt_d = pix_sat;
    end

    line_ctr_d = line_ctr;
    if ((state_q == WAIT_SOF) && fval_rise && !kill) begin
      line_ctr_d = '0;
    end else if (in_active && lval_fall) begin
      line_ctr_d = line_sat;
    end
  end

  // Frame FSM: next state plus arm acceptance.
  always_comb begin
    state_d  = state_q;
    arm_take = 1'b0;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Abort wins over a simultaneous arm.
          if (arm && locked && !abort) begin
            state_d  = ARMED;
            arm_take = 1'b1;
          end
        end
        ARMED: begin
          // Let a frame already in progress run out before looking for a start.
          if (!fval_r[0]) state_d = WAIT_SOF;
        end
        WAIT_SOF: begin
          if (fval_rise) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (fval_fall) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; cleared only when a new capture is armed.
  always_comb begin
    if (arm_take) begin
      err_d = 3'b000;
    end else begin
      err_d = err | {in_active & misalign,
                     cnt_beat & cl.fifo_full,
                     in_active & lval_fall & (pix_cnt != line_width)};
    end
  end

  // Input capture registers.
  always_ff @(posedge rxclk_div_1 or posedge sys_rst) begin
    if (sys_rst) begin
      port_r  <= '0;
      lval_r  <= '0;
      fval_r  <= '0;
      dval_r  <= '0;
      fval0_d <= 1'b0;
      lval0_d <= 1'b0;
    end else begin
      port_r  <= cl.port_in;
      lval_r  <= cl.lval;
      fval_r  <= cl.fval;
      dval_r  <= cl.dval;
      fval0_d <= fval_r[0];
      lval0_d <= lval_r[0];
    end
  end

  // FSM state, mode latch and status outputs.
  always_ff @(posedge rxclk_div_1 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      line_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      // DONE is only entered from a completed frame, so this pulses exactly in DONE.
      frame_done <= (state_d == DONE);
      if (arm_take) mode_q <= mode12;
      // Load on entry to DONE so line_cnt is already valid alongside frame_done.
      if (state_d == DONE) line_cnt <= line_ctr_d;
    end
  end

  // Pixel/line counters and error flags.
  always_ff @(posedge rxclk_div_1 or posedge sys_rst) begin
    if (sys_rst) begin
      pix_cnt  <= '0;
      line_ctr <= '0;
      err      <= 3'b000;
    end else begin
      pix_cnt  <= pix_cnt_d;
      line_ctr <= line_ctr_d;
      err      <= err_d;
    end
  end

  // Output pixel register; an abort or lock loss flushes the pending strobe.
  always_ff @(posedge rxclk_div_1 or posedge sys_rst) begin
    if (sys_rst) begin
      cl.pix_o   <= '0;
      cl.pix_vld <= 1'b0;
    end else begin
      cl.pix_vld <= cnt_beat & ~cl.fifo_full & ~kill;
      if (cnt_beat && !cl.fifo_full && !kill) cl.pix_o <= packed_pix;
    end
  end

endmodule

// File: tb/tb_camlink_frame_gate.sv
// Randomised frame stimulus against a line/beat-level reference model with a pixel scoreboard.
`timescale 1ns/1ps
module tb_camlink_frame_gate;
  localparam int NCH = 2;
  localparam int CW  = 16;

  logic          rxclk_div_1 = 1'b0;
  logic          sys_rst     = 1'b1;
  logic          locked      = 1'b1;
  logic          mode12      = 1'b0;
  logic          arm         = 1'b0;
  logic          abort       = 1'b0;
  logic [CW-1:0] line_width  = 16'd16;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] line_cnt;
  logic [2:0]    err;

  camlink_frame_gate_if #(.NCH(NCH)) cl ();

  camlink_frame_gate #(.NCH(NCH), .CW(CW), .DVAL_EN(1)) dut (
    .rxclk_div_1 (rxclk_div_1),
    .sys_rst     (sys_rst),
    .locked      (locked),
    .cl          (cl),
    .mode12      (mode12),
    .arm         (arm),
    .abort       (abort),
    .line_width  (line_width),
    .busy        (busy),
    .frame_done  (frame_done),
    .line_cnt    (line_cnt),
    .err         (err)
  );

  always #5 rxclk_div_1 = ~rxclk_div_1;

  typedef struct packed {
    logic [47:0] port;
    logic [1:0]  lv;
    logic [1:0]  fv;
    logic [1:0]  dv;
    logic        full;
  } cyc_t;

  typedef struct packed {
    logic [15:0] lines;
    logic [2:0]  e;
  } frm_t;

  cyc_t        stim[$];
  logic [47:0] sb_q[$];
  frm_t        fq[$];
  int          n_chk   = 0;
  int          n_pass  = 0;
  int          vld_cnt = 0;
  int          exp_vld = 0;
  bit          ignore  = 1'b0;
  bit          cur_mode = 1'b1;
  int          last_lc = 0;
  logic [47:0] mon_exp;
  frm_t        mon_f;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int step_of(input bit m12);
    return m12 ? 2*NCH : 3*NCH;
  endfunction

  // Pixel word the sink should see for one beat of port bytes.
  function automatic logic [47:0] pack(input logic [47:0] p, input bit m12);
    logic [47:0] r;
    logic [23:0] w;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      w = p[24*c +: 24];
      r[24*c +: 24] = m12 ? {w[15:12], w[23:16], w[11:8], w[7:0]} : w;
    end
    return r;
  endfunction

  // Builds one frame cycle by cycle and records what a capture of it must produce.
  task automatic gen_frame(input int nl, input int bpl, input int short_ln, input int full_ln,
                           input bit skew, input bit fixed, input bit cap);
    cyc_t       c;
    logic [2:0] e;
    frm_t       f;
    int         base;
    int         nbeat;
    int         k;
    base = stim.size();
    e = 3'b000;
    repeat (4) begin c = '0; stim.push_back(c); end
    repeat (2) begin c = '0; c.fv = 2'b11; stim.push_back(c); end
    for (int l = 0; l < nl; l++) begin
      nbeat = (l == short_ln) ? 3 : bpl;
      if (nbeat * step_of(cur_mode) != int'(line_width)) e[0] = 1'b1;
      k = 0;
      while (k < nbeat) begin
        c = '0;
        c.fv = 2'b11;
        c.lv = 2'b11;
        c.port = fixed ? 48'h332211332211 : 48'({$urandom, $urandom});
        if (!fixed && $urandom_range(3) == 0) begin
          c.dv = 2'($urandom_range(2));
        end else begin
          c.dv = 2'b11;
          c.full = (l == full_ln) && (k == 1 || k == 2);
          if (c.full) e[1] = 1'b1;
          if (cap && !c.full) begin
            sb_q.push_back(pack(c.port, cur_mode));
            exp_vld++;
          end
          k++;
        end
        stim.push_back(c);
      end
      repeat ((l == nl - 1) ? 2 : $urandom_range(1, 3)) begin
        c = '0; c.fv = 2'b11; stim.push_back(c);
      end
    end
    repeat (3) begin c = '0; stim.push_back(c); end
    if (skew) begin
      for (int i = stim.size() - 1; i > base; i--) begin
        c = stim[i];
        c.fv[1] = stim[i-1].fv[0];
        stim[i] = c;
      end
      e[2] = 1'b1;
    end
    if (cap) begin
      f.lines = 16'(nl);
      f.e = e;
      fq.push_back(f);
    end
  endtask

  // Drives the stimulus queue; each beat's fifo_full lands when the DUT evaluates it.
  task automatic play(input int arm_i, input int abort_i, input int lock_i, input int rst_i,
                      input int flip_i);
    int ev;
    ev = (abort_i >= 0) ? abort_i : (lock_i >= 0) ? lock_i : rst_i;
    mode12 = cur_mode;
    for (int i = 0; i < stim.size(); i++) begin
      @(posedge rxclk_div_1); #1;
      cl.port_in   = stim[i].port;
      cl.lval      = stim[i].lv;
      cl.fval      = stim[i].fv;
      cl.dval      = stim[i].dv;
      cl.fifo_full = (i > 0) ? stim[i-1].full : 1'b0;
      arm   = (i == arm_i);
      abort = (i == abort_i);
      if (i == flip_i) mode12 = ~mode12;
      if (lock_i >= 0) locked = !(i >= lock_i && i < lock_i + 3);
      if (rst_i >= 0) sys_rst = (i >= rst_i && i < rst_i + 2);
      if (i == rst_i) begin
        #1;
        chk("rst_mid_pix_vld", cl.pix_vld, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_frame_done", frame_done, 0);
        chk("rst_mid_line_cnt", line_cnt, 0);
        chk("rst_mid_err", err, 0);
      end
      if ((abort_i >= 0 && i == abort_i + 1) || (lock_i >= 0 && i == lock_i + 1)) begin
        #2;
        chk("kill_busy", busy, 0);
        chk("kill_pix_vld", cl.pix_vld, 0);
      end
      if (ev >= 0 && i == ev + 2) ignore = 1'b0;
    end
    stim.delete();
    @(posedge rxclk_div_1); #1;
    cl.port_in = '0; cl.lval = '0; cl.fval = '0; cl.dval = '0; cl.fifo_full = 1'b0;
    arm = 1'b0; abort = 1'b0; locked = 1'b1; sys_rst = 1'b0;
    mode12 = cur_mode;
    repeat (4) @(posedge rxclk_div_1);
    #1;
  endtask

  task automatic after_frame(input int lines, input logic [2:0] e);
    chk("vld_count", vld_cnt, exp_vld);
    chk("sb_drained", sb_q.size(), 0);
    chk("frames_drained", fq.size(), 0);
    chk("line_cnt_hold", line_cnt, lines);
    chk("err_sticky", err, e);
    chk("busy_idle", busy, 0);
  endtask

  // Monitor: every pixel strobe and frame_done pulse is matched against the model.
  always @(negedge rxclk_div_1) begin
    if (!sys_rst) begin
      if (cl.pix_vld && !ignore) begin
        vld_cnt++;
        if (sb_q.size() == 0) chk("pix_vld_unexpected", cl.pix_vld, 0);
        else begin
          mon_exp = sb_q.pop_front();
          chk("pix_o", cl.pix_o, mon_exp);
        end
      end
      if (frame_done) begin
        if (fq.size() == 0) chk("frame_done_unexpected", frame_done, 0);
        else begin
          mon_f = fq.pop_front();
          chk("frame_line_cnt", line_cnt, mon_f.lines);
          chk("frame_err", err, mon_f.e);
        end
      end
    end
  end

  initial begin
    int nl;
    int bpl;
    cl.port_in = '0; cl.lval = '0; cl.fval = '0; cl.dval = '0; cl.fifo_full = 1'b0;
    repeat (3) @(posedge rxclk_div_1);
    #1;
    chk("rst_pix_vld", cl.pix_vld, 0);
    chk("rst_pix_o", cl.pix_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_err", err, 0);
    sys_rst = 1'b0;
    @(posedge rxclk_div_1); #1 arm = 1'b1;
    @(posedge rxclk_div_1); #1 arm = 1'b0;
    chk("arm_after_rst_busy", busy, 1);
    abort = 1'b1;
    @(posedge rxclk_div_1); #1 abort = 1'b0;
    chk("abort_armed_busy", busy, 0);
    arm = 1'b1; abort = 1'b1;
    @(posedge rxclk_div_1); #1 arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", busy, 0);
    @(posedge rxclk_div_1); #1;
    chk("arm_abort_idle2", busy, 0);

    // Normal 12-bit frame: 3 lines x 4 beats, 16 pixels per line.
    cur_mode = 1'b1; line_width = 16;
    gen_frame(3, 4, -1, -1, 1'b0, 1'b0, 1'b1);
    play(0, -1, -1, -1, -1);
    chk("normal_12_pulses", vld_cnt, 12);
    after_frame(3, 3'b000); last_lc = 3;

    // 8-bit mode with fixed bytes.
    cur_mode = 1'b0; line_width = 24;
    gen_frame(2, 4, -1, -1, 1'b0, 1'b1, 1'b1);
    play(0, -1, -1, -1, -1);
    after_frame(2, 3'b000); last_lc = 2;

    // Random geometry and mode; odd frames flip mode12 mid-frame.
    for (int t = 0; t < 4; t++) begin
      cur_mode = 1'($urandom_range(1));
      nl  = $urandom_range(1, 5);
      bpl = $urandom_range(2, 8);
      line_width = 16'(bpl * step_of(cur_mode));
      gen_frame(nl, bpl, -1, -1, 1'b0, 1'b0, 1'b1);
      play(0, -1, -1, -1, (t % 2 == 1) ? 8 : -1);
      after_frame(nl, 3'b000); last_lc = nl;
    end

    // Arm while a frame is in progress: that frame is skipped, the next is captured.
    cur_mode = 1'b1; line_width = 16;
    gen_frame(2, 4, -1, -1, 1'b0, 1'b0, 1'b0);
    gen_frame(3, 4, -1, -1, 1'b0, 1'b0, 1'b1);
    play(10, -1, -1, -1, -1);
    after_frame(3, 3'b000); last_lc = 3;

    // Two beats dropped by backpressure: overflow only.
    gen_frame(3, 4, -1, 1, 1'b0, 1'b0, 1'b1);
    play(0, -1, -1, -1, -1);
    after_frame(3, 3'b010); last_lc = 3;

    // Short line: line-length error (also proves err cleared on arm).
    gen_frame(3, 4, 1, -1, 1'b0, 1'b0, 1'b1);
    play(0, -1, -1, -1, -1);
    after_frame(3, 3'b001); last_lc = 3;

    // fval[1] lagging fval[0]: misalignment.
    gen_frame(2, 4, -1, -1, 1'b1, 1'b0, 1'b1);
    play(0, -1, -1, -1, -1);
    after_frame(2, 3'b100); last_lc = 2;

    // Abort during ACTIVE.
    ignore = 1'b1;
    gen_frame(3, 4, -1, -1, 1'b0, 1'b0, 1'b0);
    play(0, 14, -1, -1, -1);
    after_frame(last_lc, 3'b000);

    // Loss of lock during ACTIVE.
    ignore = 1'b1;
    gen_frame(3, 4, -1, -1, 1'b0, 1'b0, 1'b0);
    play(0, -1, 14, -1, -1);
    after_frame(last_lc, 3'b000);

    // Reset mid-frame.
    ignore = 1'b1;
    gen_frame(3, 4, -1, -1, 1'b0, 1'b0, 1'b0);
    play(0, -1, -1, 14, -1);
    after_frame(0, 3'b000); last_lc = 0;

    // Recovery after reset.
    gen_frame(2, 4, -1, -1, 1'b0, 1'b0, 1'b1);
    play(0, -1, -1, -1, -1);
    after_frame(2, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
